// File: rtl/motor_interlock_gate.sv
// motor_interlock_gate: key-armed interlock in front of the motor control bits.
// A received frame only reaches the drivers after g_ArmCount consecutive frames
// carrying the interlock key; a lost key, loopback, local safe request or frame
// watchdog expiry drops the outputs to the all-ones (drivers off) value.
// Optional fault statistics counter: define MOTOR_INTERLOCK_STATS_EN.

package motor_interlock_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;

   localparam logic [31:0] GEFE_INTERLOCK = 32'h6EFE_0A5C;
endpackage

module motor_interlock_gate
   import motor_interlock_pkg::*;
#(
   parameter int          g_Motors        = 16,
   parameter int          g_CtrlBits      = 4,
   parameter logic [31:0] g_Key           = GEFE_INTERLOCK,
   parameter int          g_ArmCount      = 4,
   parameter int          g_TimeoutCycles = 1000
) (
   input  ckrs_t                            ClkRs_ix,
   input  logic                             frame_valid_i,
   input  logic [g_Motors*g_CtrlBits-1:0]   ctrl_ib,
   input  logic [31:0]                      key_ib32,
   input  logic                             loopback_i,
   input  logic                             force_safe_i,
   input  logic                             clear_fault_i,
   output logic [g_Motors*g_CtrlBits-1:0]   ctrl_ob,
   output logic [1:0]                       state_ob2,
   output logic                             active_o,
   output logic                             fault_o,
   output logic [15:0]                      fault_count_ob16
);

   localparam int         W          = g_Motors * g_CtrlBits;
   localparam logic [7:0] ARM_TARGET = 8'(g_ArmCount);
   localparam logic [19:0] WD_LIMIT  = 20'(g_TimeoutCycles);

   typedef enum logic [1:0] {
      SAFE   = 2'd0,
      ARMING = 2'd1,
      ACTIVE = 2'd2,
      FAULT  = 2'd3
   } state_t;

   logic          clk;
   logic          srst;
   logic          match;
   logic          timeout;
   state_t        state_reg, state_next;
   logic [7:0]    arm_reg, arm_next;
   logic [W-1:0]  ctrl_reg, ctrl_next;
   logic [19:0]   wd_reg;
   logic          active_reg, fault_reg;

   assign clk  = ClkRs_ix.clk;
   assign srst = ClkRs_ix.reset;

   assign match   = (key_ib32 == g_Key) && !loopback_i && !force_safe_i;
   assign timeout = (wd_reg == WD_LIMIT);

   // Frame watchdog: restarts on every frame, saturates at the limit.
   always_ff @(posedge clk) begin
      if (srst)
         wd_reg <= '0;
      else if (frame_valid_i)
         wd_reg <= '0;
      else if (!timeout)
         wd_reg <= wd_reg + 20'd1;
   end

   // Next state, arm counter and gated control word.
   always_comb begin
      state_next = state_reg;
      arm_next   = arm_reg;
      ctrl_next  = '1;
      unique case (state_reg)
         SAFE: begin
            arm_next = '0;
            if (frame_valid_i && match) begin
               if (ARM_TARGET == 8'd1) begin
                  state_next = ACTIVE;
                  ctrl_next  = ctrl_ib;
               end else begin
                  state_next = ARMING;
                  arm_next   = 8'd1;
               end
            end
         end
         ARMING: begin
            if (!match || timeout) begin
               state_next = SAFE;
               arm_next   = '0;
            end else if (frame_valid_i) begin
               arm_next = arm_reg + 8'd1;
               if (arm_reg + 8'd1 == ARM_TARGET) begin
                  state_next = ACTIVE;
                  arm_next   = '0;
                  ctrl_next  = ctrl_ib;
               end
            end
         end
         ACTIVE: begin
            ctrl_next = ctrl_reg;
            if (!match || timeout) begin
               // The frame of this cycle, if any, is dropped.
               state_next = FAULT;
               ctrl_next  = '1;
            end else if (frame_valid_i) begin
               ctrl_next = ctrl_ib;
            end
         end
         FAULT: begin
            if (clear_fault_i && !timeout)
               state_next = SAFE;
         end
         default: state_next = SAFE;
      endcase
   end

   // State register with status flags registered alongside it.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg  <= SAFE;
         arm_reg    <= '0;
         ctrl_reg   <= '1;
         active_reg <= 1'b0;
         fault_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         arm_reg    <= arm_next;
         ctrl_reg   <= ctrl_next;
         active_reg <= (state_next == ACTIVE);
         fault_reg  <= (state_next == FAULT);
      end
   end

`ifdef MOTOR_INTERLOCK_STATS_EN
   logic [15:0] fault_count_reg;
   logic        fault_hit;

   assign fault_hit = (state_reg == ACTIVE) && (state_next == FAULT);

   // Saturating count of ACTIVE-to-FAULT drops; only reset clears it.
   always_ff @(posedge clk) begin
      if (srst)
         fault_count_reg <= '0;
      else if (fault_hit && (fault_count_reg != 16'hFFFF))
         fault_count_reg <= fault_count_reg + 16'd1;
   end

   assign fault_count_ob16 = fault_count_reg;
`else
   assign fault_count_ob16 = '0;
`endif

   assign ctrl_ob   = ctrl_reg;
   assign state_ob2 = state_reg;
   assign active_o  = active_reg;
   assign fault_o   = fault_reg;

endmodule

// File: tb/tb_motor_interlock_gate.sv
// Directed bench for motor_interlock_gate: arming, hold, watchdog fault,
// loopback fault, fault clearing rules, abort paths and reset in ACTIVE.

module tb_motor_interlock_gate;
   import motor_interlock_pkg::*;

   localparam int          M   = 16;
   localparam int          CB  = 4;
   localparam int          W   = M * CB;
   localparam int          TO  = 16;
   localparam logic [31:0] KEY = GEFE_INTERLOCK;
   localparam logic [W-1:0] ONES = '1;

   logic          clk;
   logic          srst;
   ckrs_t         clkrs;
   logic          frame_valid;
   logic [W-1:0]  ctrl_in;
   logic [31:0]   key;
   logic          loopback;
   logic          force_safe;
   logic          clear_fault;
   logic [W-1:0]  ctrl_out;
   logic [1:0]    state;
   logic          active;
   logic          fault;
   logic [15:0]   fault_count;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_fc1;
   int exp_fc2;

   logic [W-1:0] vec [0:7];
   logic [1:0]   exp_arm [0:3];

   assign clkrs = '{clk: clk, reset: srst};

   motor_interlock_gate #(
      .g_Motors        (M),
      .g_CtrlBits      (CB),
      .g_Key           (KEY),
      .g_ArmCount      (4),
      .g_TimeoutCycles (TO)
   ) dut (
      .ClkRs_ix         (clkrs),
      .frame_valid_i    (frame_valid),
      .ctrl_ib          (ctrl_in),
      .key_ib32         (key),
      .loopback_i       (loopback),
      .force_safe_i     (force_safe),
      .clear_fault_i    (clear_fault),
      .ctrl_ob          (ctrl_out),
      .state_ob2        (state),
      .active_o         (active),
      .fault_o          (fault),
      .fault_count_ob16 (fault_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
      $display("check %-22s observed %h expected %h", tag, obs, expv);
   endtask

   initial begin
`ifdef MOTOR_INTERLOCK_STATS_EN
      exp_fc1 = 1;
      exp_fc2 = 2;
`else
      exp_fc1 = 0;
      exp_fc2 = 0;
`endif
      vec[0] = 64'h0123_4567_89AB_CDEF;
      vec[1] = 64'h1111_2222_3333_4444;
      vec[2] = 64'hA5A5_5A5A_F0F0_0F0F;
      vec[3] = 64'h0F1E_2D3C_4B5A_6978;
      vec[4] = 64'hDEAD_BEEF_0000_1234;
      vec[5] = 64'h5555_AAAA_5555_AAAA;
      vec[6] = 64'h0000_0000_0000_0001;
      vec[7] = 64'h8765_4321_0FED_CBA9;
      exp_arm[0] = 2'd1;
      exp_arm[1] = 2'd1;
      exp_arm[2] = 2'd1;
      exp_arm[3] = 2'd2;

      clk = 1'b0; srst = 1'b1; frame_valid = 1'b0; ctrl_in = '0;
      key = '0; loopback = 1'b0; force_safe = 1'b0; clear_fault = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_state",  W'(state), W'(2'd0));
      check("rst_ctrl",   ctrl_out, ONES);
      check("rst_active", W'(active), W'(1'b0));
      check("rst_fault",  W'(fault), W'(1'b0));
      check("rst_fcount", W'(fault_count), W'(16'd0));
      srst = 1'b0;
      key  = KEY;

      // Four good frames arm the gate: states 1,1,1,2
      for (int i = 0; i < 4; i++) begin
         frame_valid = 1'b1;
         ctrl_in     = vec[i];
         tick();
         check($sformatf("arm_state_%0d", i), W'(state), W'(exp_arm[i]));
         if (i < 3)
            check($sformatf("arm_ctrl_%0d", i), ctrl_out, ONES);
      end
      check("active_ctrl_load", ctrl_out, vec[3]);
      check("active_flag",      W'(active), W'(1'b1));
      check("active_fault_flag", W'(fault), W'(1'b0));

      // Frame in ACTIVE passes through; output holds between frames
      ctrl_in = vec[4];
      tick();
      check("active_frame", ctrl_out, vec[4]);
      frame_valid = 1'b0;
      ctrl_in     = vec[5];
      tick();
      check("active_hold", ctrl_out, vec[4]);

      // Watchdog: still ACTIVE at the limit, FAULT one edge later
      repeat (TO - 1) tick();
      check("wd_edge_state", W'(state), W'(2'd2));
      check("wd_edge_ctrl",  ctrl_out, vec[4]);
      tick();
      check("wd_fault_state", W'(state), W'(2'd3));
      check("wd_fault_flag",  W'(fault), W'(1'b1));
      check("wd_active_flag", W'(active), W'(1'b0));
      check("wd_fault_ctrl",  ctrl_out, ONES);
      check("wd_fault_count", W'(fault_count), W'(exp_fc1));

      // Clear ignored while the watchdog is expired
      clear_fault = 1'b1;
      tick();
      check("clr_in_timeout", W'(state), W'(2'd3));
      frame_valid = 1'b1;
      ctrl_in     = vec[0];
      tick();
      check("clr_same_edge_to", W'(state), W'(2'd3));
      tick();
      check("clr_flowing", W'(state), W'(2'd0));
      check("clr_ctrl",    ctrl_out, ONES);
      clear_fault = 1'b0;

      // Bad key after two good frames aborts; four more good frames needed
      tick();
      check("rearm1_state", W'(state), W'(2'd1));
      tick();
      check("rearm2_state", W'(state), W'(2'd1));
      key = 32'h0;
      tick();
      check("badkey_abort", W'(state), W'(2'd0));
      key = KEY;
      tick(); tick(); tick();
      check("rearm_third", W'(state), W'(2'd1));
      check("rearm_third_ctrl", ctrl_out, ONES);
      tick();
      check("rearm_active", W'(state), W'(2'd2));
      check("rearm_ctrl",   ctrl_out, vec[0]);

      // Loopback with a good frame in ACTIVE faults and drops the frame
      loopback = 1'b1;
      ctrl_in  = vec[6];
      tick();
      check("lb_fault_state", W'(state), W'(2'd3));
      check("lb_fault_ctrl",  ctrl_out, ONES);
      check("lb_fault_count", W'(fault_count), W'(exp_fc2));
      loopback    = 1'b0;
      clear_fault = 1'b1;
      tick();
      check("lb_clear", W'(state), W'(2'd0));
      clear_fault = 1'b0;

      // Non-matching frames in SAFE never arm
      key = 32'h0;
      tick();
      check("safe_badkey", W'(state), W'(2'd0));
      key        = KEY;
      force_safe = 1'b1;
      tick();
      check("safe_force", W'(state), W'(2'd0));
      force_safe = 1'b0;
      tick();
      check("arm_again", W'(state), W'(2'd1));
      frame_valid = 1'b0;
      force_safe  = 1'b1;
      tick();
      check("arming_force_abort", W'(state), W'(2'd0));
      force_safe = 1'b0;

      // Re-arm and pulse reset in ACTIVE
      frame_valid = 1'b1;
      ctrl_in     = vec[7];
      repeat (4) tick();
      check("final_active", W'(state), W'(2'd2));
      check("final_ctrl",   ctrl_out, vec[7]);
      frame_valid = 1'b0;
      srst        = 1'b1;
      tick();
      check("rst_act_state",  W'(state), W'(2'd0));
      check("rst_act_ctrl",   ctrl_out, ONES);
      check("rst_act_active", W'(active), W'(1'b0));
      check("rst_act_fault",  W'(fault), W'(1'b0));
      check("rst_act_fcount", W'(fault_count), W'(16'd0));
      srst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_interlock_gate.md
MOTOR_INTERLOCK_GATE -- requirements
Module: motor_interlock_gate

Interface
REQ-001 The block SHALL have parameter g_Motors, default 16, giving the number of motor channels.
REQ-002 The block SHALL have parameter g_CtrlBits, default 4, giving the control bits per motor.
REQ-003 The block SHALL have parameter g_Key, default GEFE_INTERLOCK, giving the 32-bit interlock word that enables drive.
REQ-004 The block SHALL have parameter g_ArmCount, default 4, giving the consecutive matching frames needed to arm (range 1..255).
REQ-005 The block SHALL have parameter g_TimeoutCycles, default 1000, giving the watchdog limit in clock cycles between frames (range 2..2^20-1).
REQ-006 The block SHALL have port ClkRs_ix, input, ckrs_t: .clk is the single clock; .reset is a synchronous, active-high reset.
REQ-007 The block SHALL have port frame_valid_i, input, 1 bit: strobe marking a new control frame.
REQ-008 The block SHALL have port ctrl_ib, input, g_Motors*g_CtrlBits bits: requested motor control bits.
REQ-009 The block SHALL have port key_ib32, input, 32 bits: interlock word received from VFC.
REQ-010 The block SHALL have port loopback_i, input, 1 bit: stream loopback request (page selector MSB).
REQ-011 The block SHALL have port force_safe_i, input, 1 bit: local safe-state request.
REQ-012 The block SHALL have port clear_fault_i, input, 1 bit: fault acknowledge.
REQ-013 The block SHALL have port ctrl_ob, output, g_Motors*g_CtrlBits bits: gated motor control.
REQ-014 The block SHALL have port state_ob2, output, 2 bits: FSM state, encoded SAFE=0, ARMING=1, ACTIVE=2, FAULT=3.
REQ-015 The block SHALL have port active_o, output, 1 bit: high only in ACTIVE.
REQ-016 The block SHALL have port fault_o, output, 1 bit: high only in FAULT.
REQ-017 The block SHALL have port fault_count_ob16, output, 16 bits: count of faults (see Configuration).

Function
REQ-018 The block SHALL compute match = (key_ib32 == g_Key) && !loopback_i && !force_safe_i, combinationally, every cycle.
REQ-019 The block SHALL hold a watchdog counter that is cleared on any frame_valid_i, otherwise increments, and saturates at g_TimeoutCycles; timeout = (counter == g_TimeoutCycles).
REQ-020 In SAFE, a cycle with frame_valid_i and match SHALL go to ARMING with arm counter = 1; if g_ArmCount = 1 it SHALL go directly to ACTIVE.
REQ-021 In ARMING, each frame_valid_i with match SHALL increment the arm counter, and on reaching g_ArmCount the block SHALL go to ACTIVE.
REQ-022 In ARMING, !match or timeout SHALL return the block to SAFE with the arm counter cleared; frames without a match SHALL never advance arming.
REQ-023 In ACTIVE, frame_valid_i with match SHALL register ctrl_ib into ctrl_ob one cycle later; between frames ctrl_ob SHALL hold its last value.
REQ-024 In ACTIVE, !match or timeout SHALL go to FAULT, and ctrl_ob SHALL become all-ones on that same clock edge; a frame arriving in the same cycle SHALL be discarded.
REQ-025 In FAULT, clear_fault_i with !timeout SHALL go to SAFE; clear_fault_i while timeout is true SHALL be ignored.
REQ-026 In SAFE, ARMING and FAULT, ctrl_ob SHALL be all-ones (all drivers deactivated, the codebase safe value).
REQ-027 The ARMING-to-ACTIVE transition SHALL load the completing frame's ctrl_ib into ctrl_ob on the same edge.
REQ-028 active_o, fault_o and state_ob2 SHALL be registered and consistent with the current state in the same cycle.

Reset
REQ-029 Reset SHALL set: state SAFE, ctrl_ob all-ones, active_o 0, fault_o 0, state_ob2 0, arm counter 0, watchdog 0, fault_count_ob16 0.
REQ-030 Reset asserted mid-ACTIVE SHALL force ctrl_ob to all-ones on the next edge, with no FAULT state and no fault count.

Configuration
REQ-031 With MOTOR_INTERLOCK_STATS_EN defined, fault_count_ob16 SHALL increment on every ACTIVE-to-FAULT transition, saturate at 16'hFFFF, and clear only on reset.
REQ-032 Without MOTOR_INTERLOCK_STATS_EN, fault_count_ob16 SHALL be constant 0, the port SHALL still exist, and no counter logic SHALL be inferred.

Verification
REQ-033 With g_ArmCount=4, four frames with key=g_Key SHALL give state_ob2 sequence 1,1,1,2, and ctrl_ob SHALL equal the 4th ctrl_ib one cycle after the 4th strobe.
REQ-034 In ARMING after 2 good frames, a frame with key=32'h0 SHALL return the block to SAFE, and 4 further good frames SHALL be required to reach ACTIVE.
REQ-035 In ACTIVE, with no frame_valid_i for g_TimeoutCycles cycles, the block SHALL enter FAULT, ctrl_ob SHALL be all-ones, fault_o SHALL be 1, and fault_count_ob16 SHALL be 1 (with the macro).
REQ-036 In ACTIVE, loopback_i=1 together with a good frame SHALL cause FAULT, and the frame's ctrl_ib SHALL not appear on ctrl_ob.
REQ-037 In FAULT, clear_fault_i while frames keep flowing SHALL give SAFE next cycle; clear_fault_i held during timeout SHALL leave the block in FAULT.
REQ-038 Reset pulsed in ACTIVE SHALL give ctrl_ob all-ones and state 0 on the next edge, with fault_count unchanged from 0.
